// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 frame-buffer readout slice:
// frame-buffer port widths and the row-load FSM encoding.
package hub75_pkg;

    localparam int FB_AW = 13;
    localparam int FB_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } rd_state_t;

endpackage

// File: rtl/hub75_linebuffer.sv
// One line of pixels: N_COLS entries of N_BANKS words, masked
// per-word writes and a registered read that holds when rd_en is low.
module hub75_linebuffer
    import hub75_pkg::*;
#(
    parameter int N_BANKS = 2,
    parameter int N_COLS  = 64,
    parameter int W       = 24,
    localparam int AW     = $clog2(N_COLS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        wr_addr,
    input  logic [N_BANKS-1:0]   wr_mask,
    input  logic [N_BANKS*W-1:0] wr_data,
    input  logic [AW-1:0]        rd_addr,
    input  logic                 rd_en,
    output logic [N_BANKS*W-1:0] rd_data
);

    logic [N_BANKS*W-1:0] mem [N_COLS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < N_BANKS; b++) begin
            if (wr_mask[b]) begin
                mem[wr_addr][b*W +: W] <= wr_data[b*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/hub75_fb_readout.sv
// Loads one panel row from the frame buffer into a line buffer and serves
// scan-side column reads. Define HUB75_READOUT_DBLBUF_EN for front/back buffers.
module hub75_fb_readout
    import hub75_pkg::*;
#(
    parameter int N_BANKS  = 2,
    parameter int N_ROWS   = 32,
    parameter int N_COLS   = 64,
    parameter int N_CHANS  = 3,
    parameter int N_PLANES = 8,
    localparam int W           = N_CHANS * N_PLANES,
    localparam int LOG_N_ROWS  = $clog2(N_ROWS),
    localparam int LOG_N_COLS  = $clog2(N_COLS),
    localparam int LOG_N_BANKS = $clog2(N_BANKS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LOG_N_ROWS-1:0] rd_row_addr,
    input  logic                  rd_row_load,
    output logic                  rd_row_rdy,
    input  logic                  rd_row_swap,
    input  logic [LOG_N_COLS-1:0] rd_col_addr,
    input  logic                  rd_en,
    output logic [N_BANKS*W-1:0]  rd_data,
    output logic                  ctrl_req,
    input  logic                  ctrl_gnt,
    output logic                  ctrl_rel,
    output logic [FB_AW-1:0]      fb_addr,
    output logic                  fb_rden,
    input  logic [FB_DW-1:0]      fb_data
);

    localparam int K_W = LOG_N_COLS + LOG_N_BANKS + 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(2 * N_BANKS * N_COLS - 1);

    rd_state_t state, state_nx;

    logic [LOG_N_ROWS-1:0] row_q;
    logic [K_W-1:0]        k;
    logic [K_W-1:0]        ret_k;
    logic                  ret_vld;
    logic [FB_DW-1:0]      lo_q;

    logic                  wr_en;
    logic [LOG_N_COLS-1:0] wr_col;
    logic [N_BANKS-1:0]    wr_mask;
    logic [W-1:0]          wr_pix;
    logic [N_BANKS*W-1:0]  wr_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (rd_row_load) state_nx = ST_REQ;
            ST_REQ:   if (ctrl_gnt) state_nx = ST_RUN;
            ST_RUN:   if (k == K_LAST) state_nx = ST_DRAIN;
            ST_DRAIN: if (wr_en && ret_k == K_LAST) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_row_rdy = 1'b0;
        ctrl_req   = 1'b0;
        ctrl_rel   = 1'b0;
        fb_rden    = 1'b0;
        fb_addr    = '0;
        unique case (state)
            ST_IDLE:  rd_row_rdy = 1'b1;
            ST_REQ:   ctrl_req = 1'b1;
            ST_RUN: begin
                fb_rden = 1'b1;
                fb_addr = {row_q, k};
            end
            ST_DRAIN: ctrl_rel = 1'b1;
            default: ;
        endcase
    end

    // k doubles as the low address bits: {col, bank, half}
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q   <= '0;
            k       <= '0;
            ret_vld <= 1'b0;
            ret_k   <= '0;
            lo_q    <= '0;
        end else begin
            if (state == ST_IDLE && rd_row_load) row_q <= rd_row_addr;
            if (state == ST_RUN) k <= k + 1'b1;
            else k <= '0;
            ret_vld <= fb_rden;
            ret_k   <= k;
            if (ret_vld && !ret_k[0]) lo_q <= fb_data;
        end
    end

    assign wr_en   = ret_vld && ret_k[0];
    assign wr_col  = ret_k[K_W-1 -: LOG_N_COLS];
    assign wr_mask = {N_BANKS{wr_en}}
                   & (N_BANKS'(1) << (ret_k[K_W-LOG_N_COLS-1:0] >> 1));
    assign wr_pix  = {fb_data[W-17:0], lo_q};
    assign wr_data = {N_BANKS{wr_pix}};

`ifdef HUB75_READOUT_DBLBUF_EN
    logic                 sel;
    logic                 rd_sel;
    logic [N_BANKS*W-1:0] rd0;
    logic [N_BANKS*W-1:0] rd1;

    // sel names the front buffer; the load always fills the other one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel    <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            if (rd_row_swap && state == ST_IDLE) sel <= ~sel;
            if (rd_en) rd_sel <= sel;
        end
    end

    hub75_linebuffer #(
        .N_BANKS (N_BANKS),
        .N_COLS  (N_COLS),
        .W       (W)
    ) u_lb0 (
        .clk     (clk),
        .rst     (rst),
        .wr_addr (wr_col),
        .wr_mask (sel ? wr_mask : '0),
        .wr_data (wr_data),
        .rd_addr (rd_col_addr),
        .rd_en   (rd_en),
        .rd_data (rd0)
    );

    hub75_linebuffer #(
        .N_BANKS (N_BANKS),
        .N_COLS  (N_COLS),
        .W       (W)
    ) u_lb1 (
        .clk     (clk),
        .rst     (rst),
        .wr_addr (wr_col),
        .wr_mask (sel ? '0 : wr_mask),
        .wr_data (wr_data),
        .rd_addr (rd_col_addr),
        .rd_en   (rd_en),
        .rd_data (rd1)
    );

    assign rd_data = rd_sel ? rd1 : rd0;
`else
    logic unused_swap;
    assign unused_swap = rd_row_swap;

    hub75_linebuffer #(
        .N_BANKS (N_BANKS),
        .N_COLS  (N_COLS),
        .W       (W)
    ) u_lb (
        .clk     (clk),
        .rst     (rst),
        .wr_addr (wr_col),
        .wr_mask (wr_mask),
        .wr_data (wr_data),
        .rd_addr (rd_col_addr),
        .rd_en   (rd_en),
        .rd_data (rd_data)
    );
`endif

endmodule

// File: tb/tb_hub75_fb_readout.sv
// Directed bench for hub75_fb_readout; frame-buffer model returns
// word(addr) = addr one cycle after fb_rden.
module tb_hub75_fb_readout;
    import hub75_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_row_addr;
    logic        rd_row_load;
    logic        rd_row_rdy;
    logic        rd_row_swap;
    logic [5:0]  rd_col_addr;
    logic        rd_en;
    logic [47:0] rd_data;
    logic        ctrl_req;
    logic        ctrl_gnt;
    logic        ctrl_rel;
    logic [12:0] fb_addr;
    logic        fb_rden;
    logic [15:0] fb_data;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hub75_fb_readout dut (
        .clk         (clk),
        .rst         (rst),
        .rd_row_addr (rd_row_addr),
        .rd_row_load (rd_row_load),
        .rd_row_rdy  (rd_row_rdy),
        .rd_row_swap (rd_row_swap),
        .rd_col_addr (rd_col_addr),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .ctrl_req    (ctrl_req),
        .ctrl_gnt    (ctrl_gnt),
        .ctrl_rel    (ctrl_rel),
        .fb_addr     (fb_addr),
        .fb_rden     (fb_rden),
        .fb_data     (fb_data)
    );

    always @(posedge clk) begin
        fb_data <= fb_rden ? {3'b000, fb_addr} : 16'hdead;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [23:0] pix(input int row, input int col,
                                        input int bank);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = 16'(row * 256 + col * 4 + bank * 2);
        hi = lo + 16'd1;
        return {hi[7:0], lo};
    endfunction

    function automatic logic [47:0] line(input int row, input int col);
        return {pix(row, col, 1), pix(row, col, 0)};
    endfunction

    task automatic do_swap();
        rd_row_swap = 1'b1;
        @(negedge clk);
        rd_row_swap = 1'b0;
    endtask

    task automatic rd_col(input int col, input logic [47:0] exp,
                          input string tag);
        rd_col_addr = 6'(col);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check(tag, rd_data, exp);
        rd_col_addr = 6'(col ^ 1);
        @(negedge clk);
        check({tag, "_hold"}, rd_data, exp);
    endtask

    task automatic do_load(input int row, input int gnt_dly, input bit swap,
                           input bit poke, input bit fchk,
                           input logic [47:0] fexp);
        int cyc, nrd, aerr, nrel, rel_at, herr, last_rd;
        rd_row_addr = 5'(row);
        rd_row_load = 1'b1;
        rd_row_swap = swap;
        @(negedge clk);
        rd_row_load = 1'b0;
        rd_row_swap = 1'b0;
        check("req_up", ctrl_req, 1);
        check("rdy_low", rd_row_rdy, 0);
        herr = 0;
        for (int i = 0; i < gnt_dly; i++) begin
            if (!ctrl_req || fb_rden || ctrl_rel) herr++;
            @(negedge clk);
        end
        check("req_hold", herr, 0);
        ctrl_gnt = 1'b1;
        cyc = 0; nrd = 0; aerr = 0; nrel = 0; rel_at = 0; last_rd = 0;
        while (!rd_row_rdy && cyc < 1000) begin
            @(negedge clk);
            ctrl_gnt = 1'b0;
            rd_row_load = 1'b0;
            rd_en = 1'b0;
            cyc++;
            if (fb_rden) begin
                if (fb_addr !== 13'(row * 256 + nrd)) aerr++;
                nrd++;
                last_rd = cyc;
            end
            if (ctrl_rel) begin
                nrel++;
                rel_at = cyc;
            end
            if (poke && cyc == 100) begin
                rd_row_load = 1'b1;
                rd_row_addr = 5'(row + 1);
            end
            if (fchk && cyc == 60) begin
                rd_col_addr = 6'd10;
                rd_en = 1'b1;
            end
            if (fchk && cyc == 61) check("front_during_load", rd_data, fexp);
        end
        check("latency", cyc, 258);
        check("n_reads", nrd, 256);
        check("addr_seq", aerr, 0);
        check("rel_pulses", nrel, 1);
        check("rel_after_last", rel_at, last_rd + 1);
        check("idle_no_req", ctrl_req, 0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        rd_row_addr = '0;
        rd_row_load = 1'b0;
        rd_row_swap = 1'b0;
        rd_col_addr = '0;
        rd_en = 1'b0;
        ctrl_gnt = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdy", rd_row_rdy, 1);
        check("rst_req", ctrl_req, 0);
        check("rst_rel", ctrl_rel, 0);
        check("rst_rden", fb_rden, 0);
        check("rst_addr", fb_addr, 0);
        check("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        @(negedge clk);

        ctrl_gnt = 1'b1;
        @(negedge clk);
        ctrl_gnt = 1'b0;
        check("gnt_idle_rdy", rd_row_rdy, 1);
        check("gnt_idle_rden", fb_rden, 0);

        do_load(5, 3, 1'b0, 1'b1, 1'b0, '0);
        do_swap();
        rd_col(10, line(5, 10), "row5_c10");

        do_load(10, 50, 1'b0, 1'b0, 1'b0, '0);
        do_swap();
        rd_col(10, 48'h2B0A2A_290A28, "row10_c10");
        rd_col(0, line(10, 0), "row10_c0");
        rd_col(63, line(10, 63), "row10_c63");

        do_load(12, 3, 1'b0, 1'b0, 1'b0, '0);
`ifdef HUB75_READOUT_DBLBUF_EN
        do_load(3, 3, 1'b1, 1'b0, 1'b1, line(12, 10));
        rd_col(10, line(12, 10), "swapload_front");
`else
        do_load(3, 3, 1'b1, 1'b0, 1'b0, '0);
        rd_col(10, line(3, 10), "single_buf_c10");
`endif
        do_swap();
        rd_col(10, line(3, 10), "row3_after_swap");

        rd_row_addr = 5'd9;
        rd_row_load = 1'b1;
        @(negedge clk);
        rd_row_load = 1'b0;
        ctrl_gnt = 1'b1;
        @(negedge clk);
        ctrl_gnt = 1'b0;
        cyc = 0;
        while (fb_addr !== 13'(9 * 256 + 100) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("k100_reached", fb_addr, 13'(9 * 256 + 100));
        #1 rst = 1'b1;
        #1;
        check("midrun_rst_rden", fb_rden, 0);
        check("midrun_rst_rdy", rd_row_rdy, 1);
        check("midrun_rst_req", ctrl_req, 0);
        check("midrun_rst_addr", fb_addr, 0);
        check("midrun_rst_rd_data", rd_data, 0);
        @(negedge clk);
        rst = 1'b0;

        do_load(20, 3, 1'b0, 1'b0, 1'b0, '0);
        do_swap();
        rd_col(10, line(20, 10), "row20_c10");
        rd_col(33, line(20, 33), "row20_c33");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
